// File: rtl/multicycle_control_unit_if.sv
// Bus between the multi-cycle control unit and the datapath it steers.
// The master side is the control unit: it samples the instruction opcode,
// the ALU zero flag and the memory handshake, and drives every datapath
// strobe/select plus the sticky error flags and the debug state.
interface multicycle_control_unit_if #(
  parameter int OPCODE_W = 3
);
  logic [OPCODE_W-1:0] opcode;
  logic                zero;
  logic                mem_ready;

  logic                pc_write;
  logic                ir_write;
  logic                reg_dst;
  logic                reg_write;
  logic                mem_read;
  logic                mem_write;
  logic                mem_to_reg;
  logic                alu_src;
  logic                jump;
  logic                branch_taken;
  logic [1:0]          alu_op;
  logic                illegal_op;
  logic                mem_timeout;
  logic [2:0]          state;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, ir_write, reg_dst, reg_write, mem_read, mem_write,
           mem_to_reg, alu_src, jump, branch_taken, alu_op,
           illegal_op, mem_timeout, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, ir_write, reg_dst, reg_write, mem_read, mem_write,
           mem_to_reg, alu_src, jump, branch_taken, alu_op,
           illegal_op, mem_timeout, state
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with a
// memory-ready handshake guarded by a wait timer, plus sticky flags for
// illegal opcodes and memory timeouts.
//
// Optional feature macro: BEQ_EN
//   defined   : opcode 7 is BEQ, resolved in the BRANCH state
//   undefined : opcode 7 is illegal and BRANCH behaves like ERROR
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | post-reset, all strobes low, moves to FETCH next cycle
// FETCH  | instruction read; IR/PC written when mem_ready arrives
// DECODE | opcode captured; NOP/J retire here, illegal -> ERROR
// EXEC   | ALU operation set up for the captured opcode
// MEM    | data access for LW/SW, waits on mem_ready
// WB     | register file write-back
// ERROR  | absorbing, all strobes low, left only through reset
// BRANCH | BEQ resolution using the ALU zero flag
module multicycle_control_unit #(
  parameter int OPCODE_W    = 3,
  parameter int TIMEOUT_W   = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                        clk,
  input  logic                        reset,
  multicycle_control_unit_if.master   bus
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;
  localparam logic [2:0] ST_ERROR  = 3'd6;
  localparam logic [2:0] ST_BRANCH = 3'd7;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_LW   = 3'd1;
  localparam logic [2:0] OP_SW   = 3'd2;
  localparam logic [2:0] OP_J    = 3'd3;
  localparam logic [2:0] OP_ADD  = 3'd4;
  localparam logic [2:0] OP_ADDI = 3'd5;
  localparam logic [2:0] OP_SUB  = 3'd6;
  localparam logic [2:0] OP_BEQ  = 3'd7;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_ARITH = 2'b10;

  localparam logic [TIMEOUT_W-1:0] TO_LIMIT = TIMEOUT_W'(MEM_TIMEOUT);

  logic [2:0]           state_q;
  logic [2:0]           state_d;
  logic [2:0]           op_q;
  logic [TIMEOUT_W-1:0] wait_cnt_q;
  logic                 illegal_q;
  logic                 timeout_q;
  logic                 set_illegal;
  logic                 set_timeout;

  logic [2:0]           op_lo;
  logic                 op_hi_zero;
  logic                 op_legal;
  logic                 wait_expired;

  logic                 pc_write;
  logic                 ir_write;
  logic                 reg_dst;
  logic                 reg_write;
  logic                 mem_read;
  logic                 mem_write;
  logic                 mem_to_reg;
  logic                 alu_src;
  logic                 jump;
  logic                 branch_taken;
  logic [1:0]           alu_op;

  // Opcode legality: zero-extended, so any set bit above the low three is illegal.
  always_comb begin
    op_lo      = bus.opcode[2:0];
    op_hi_zero = ((bus.opcode >> 3) == '0);
`ifdef BEQ_EN
    op_legal   = op_hi_zero;
`else
    op_legal   = op_hi_zero && (op_lo != OP_BEQ);
`endif
  end

  // Timer has reached its limit while still waiting on memory.
  assign wait_expired = (wait_cnt_q == TO_LIMIT) && !bus.mem_ready;

  // Next-state selection; mem_ready in the limit cycle beats the timeout.
  always_comb begin
    state_d     = state_q;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    case (state_q)
      ST_IDLE:   state_d = ST_FETCH;
      ST_FETCH: begin
        if (bus.mem_ready) begin
          state_d = ST_DECODE;
        end else if (wait_expired) begin
          state_d     = ST_ERROR;
          set_timeout = 1'b1;
        end
      end
      ST_DECODE: begin
        if (!op_legal) begin
          state_d     = ST_ERROR;
          set_illegal = 1'b1;
        end else if (op_lo == OP_NOP || op_lo == OP_J) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (op_q)
          OP_LW, OP_SW:            state_d = ST_MEM;
          OP_ADD, OP_ADDI, OP_SUB: state_d = ST_WB;
`ifdef BEQ_EN
          OP_BEQ:                  state_d = ST_BRANCH;
`endif
          default:                 state_d = ST_ERROR;
        endcase
      end
      ST_MEM: begin
        if (bus.mem_ready) begin
          state_d = (op_q == OP_LW) ? ST_WB : ST_FETCH;
        end else if (wait_expired) begin
          state_d     = ST_ERROR;
          set_timeout = 1'b1;
        end
      end
      ST_WB:     state_d = ST_FETCH;
`ifdef BEQ_EN
      ST_BRANCH: state_d = ST_FETCH;
`endif
      default:   state_d = ST_ERROR;
    endcase
  end

  // State register and opcode capture (opcode only sampled in DECODE).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NOP;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE) begin
        op_q <= op_lo;
      end
    end
  end

  // Memory-wait timer: any state change clears it, so it starts at zero on
  // entry to FETCH/MEM; it then counts stalled cycles and parks at the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= '0;
    end else if (state_d != state_q) begin
      wait_cnt_q <= '0;
    end else if ((state_q == ST_FETCH || state_q == ST_MEM) &&
                 !bus.mem_ready && (wait_cnt_q != TO_LIMIT)) begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if (set_illegal) illegal_q <= 1'b1;
      if (set_timeout) timeout_q <= 1'b1;
    end
  end

  // Datapath strobes decoded from state and captured opcode; FETCH, DECODE
  // and BRANCH also look at the live handshake/opcode/zero inputs.
  always_comb begin
    pc_write     = 1'b0;
    ir_write     = 1'b0;
    reg_dst      = 1'b0;
    reg_write    = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_to_reg   = 1'b0;
    alu_src      = 1'b0;
    jump         = 1'b0;
    branch_taken = 1'b0;
    alu_op       = ALU_ADD;
    case (state_q)
      ST_FETCH: begin
        mem_read = 1'b1;
        ir_write = bus.mem_ready;
        pc_write = bus.mem_ready;
      end
      ST_DECODE: begin
        if (op_legal && op_lo == OP_J) begin
          jump     = 1'b1;
          pc_write = 1'b1;
        end
      end
      ST_EXEC: begin
        case (op_q)
          OP_LW, OP_SW: begin
            alu_src = 1'b1;
            alu_op  = ALU_ADD;
          end
          OP_ADD, OP_SUB: alu_op = ALU_ARITH;
          OP_ADDI: begin
            alu_src = 1'b1;
            alu_op  = ALU_ARITH;
          end
`ifdef BEQ_EN
          OP_BEQ: alu_op = ALU_SUB;
`endif
          default: ;
        endcase
      end
      ST_MEM: begin
        alu_src   = 1'b1;
        mem_read  = (op_q == OP_LW);
        mem_write = (op_q == OP_SW);
      end
      ST_WB: begin
        reg_write = 1'b1;
        case (op_q)
          OP_LW: mem_to_reg = 1'b1;
          OP_ADD, OP_SUB: begin
            reg_dst = 1'b1;
            alu_op  = ALU_ARITH;
          end
          OP_ADDI: begin
            alu_src = 1'b1;
            alu_op  = ALU_ARITH;
          end
          default: ;
        endcase
      end
`ifdef BEQ_EN
      ST_BRANCH: begin
        alu_op       = ALU_SUB;
        branch_taken = bus.zero;
        pc_write     = bus.zero;
      end
`endif
      default: ;
    endcase
  end

`ifndef BEQ_EN
  // Without branches the zero flag has no consumer.
  logic unused_zero;
  assign unused_zero = bus.zero;
`endif

  assign bus.pc_write     = pc_write;
  assign bus.ir_write     = ir_write;
  assign bus.reg_dst      = reg_dst;
  assign bus.reg_write    = reg_write;
  assign bus.mem_read     = mem_read;
  assign bus.mem_write    = mem_write;
  assign bus.mem_to_reg   = mem_to_reg;
  assign bus.alu_src      = alu_src;
  assign bus.jump         = jump;
  assign bus.branch_taken = branch_taken;
  assign bus.alu_op       = alu_op;
  assign bus.illegal_op   = illegal_q;
  assign bus.mem_timeout  = timeout_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit. Each cycle drives inputs,
// pushes the expected output snapshot to a scoreboard queue, then pops and
// compares it against the settled DUT outputs. Honours BEQ_EN like the RTL.
module tb_multicycle_control_unit;

  localparam logic [9:0] S_PCW  = 10'h200;
  localparam logic [9:0] S_IRW  = 10'h100;
  localparam logic [9:0] S_RDST = 10'h080;
  localparam logic [9:0] S_RW   = 10'h040;
  localparam logic [9:0] S_MR   = 10'h020;
  localparam logic [9:0] S_MW   = 10'h010;
  localparam logic [9:0] S_M2R  = 10'h008;
  localparam logic [9:0] S_AS   = 10'h004;
  localparam logic [9:0] S_J    = 10'h002;
  localparam logic [9:0] S_BT   = 10'h001;
  localparam logic [9:0] S_NONE = 10'h000;
  localparam logic [9:0] S_FETCH_OK = S_MR | S_IRW | S_PCW;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  logic [16:0] exp_q[$];
  string       tag_q[$];

  multicycle_control_unit_if #(.OPCODE_W(3)) bus ();

  multicycle_control_unit #(
    .OPCODE_W(3),
    .TIMEOUT_W(4),
    .MEM_TIMEOUT(15)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] mk(input logic [2:0] st, input logic [9:0] str,
                                     input logic [1:0] aop, input logic ill = 1'b0,
                                     input logic to = 1'b0);
    return {st, str, aop, ill, to};
  endfunction

  function automatic logic [16:0] observe();
    return {bus.state, bus.pc_write, bus.ir_write, bus.reg_dst, bus.reg_write,
            bus.mem_read, bus.mem_write, bus.mem_to_reg, bus.alu_src, bus.jump,
            bus.branch_taken, bus.alu_op, bus.illegal_op, bus.mem_timeout};
  endfunction

  // One cycle: drive, queue expectation, settle, compare, advance to next negedge.
  task automatic cyc(input logic [2:0] op, input logic z, input logic rdy,
                     input logic rst, input logic [16:0] exp, input string tag);
    logic [16:0] e;
    logic [16:0] o;
    string       t;
    bus.opcode    = op;
    bus.zero      = z;
    bus.mem_ready = rdy;
    reset         = rst;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    #1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    o = observe();
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", t, o, e);
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    total         = 0;
    bad           = 0;
    reset         = 1'b1;
    bus.opcode    = 3'd0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // ADD; opcode changes after DECODE must be ignored
    cyc(3'd4, 0, 1, 0, mk(3'd0, S_NONE, 2'b00), "reset_idle");
    cyc(3'd4, 0, 1, 0, mk(3'd1, S_FETCH_OK, 2'b00), "add_fetch");
    cyc(3'd4, 0, 1, 0, mk(3'd2, S_NONE, 2'b00), "add_decode");
    cyc(3'd1, 0, 1, 0, mk(3'd3, S_NONE, 2'b10), "add_exec");
    cyc(3'd1, 0, 1, 0, mk(3'd5, S_RDST | S_RW, 2'b10), "add_wb");

    // LW with three stalled MEM cycles
    cyc(3'd1, 0, 1, 0, mk(3'd1, S_FETCH_OK, 2'b00), "lw_fetch");
    cyc(3'd1, 0, 1, 0, mk(3'd2, S_NONE, 2'b00), "lw_decode");
    cyc(3'd0, 0, 1, 0, mk(3'd3, S_AS, 2'b00), "lw_exec");
    for (int i = 0; i < 3; i++)
      cyc(3'd0, 0, 0, 0, mk(3'd4, S_MR | S_AS, 2'b00), "lw_mem_wait");
    cyc(3'd0, 0, 1, 0, mk(3'd4, S_MR | S_AS, 2'b00), "lw_mem_done");
    cyc(3'd0, 0, 1, 0, mk(3'd5, S_RW | S_M2R, 2'b00), "lw_wb");

    // SW, zero wait
    cyc(3'd2, 0, 1, 0, mk(3'd1, S_FETCH_OK, 2'b00), "sw_fetch");
    cyc(3'd2, 0, 1, 0, mk(3'd2, S_NONE, 2'b00), "sw_decode");
    cyc(3'd2, 0, 1, 0, mk(3'd3, S_AS, 2'b00), "sw_exec");
    cyc(3'd2, 0, 1, 0, mk(3'd4, S_MW | S_AS, 2'b00), "sw_mem");

    // J and NOP retire in DECODE
    cyc(3'd3, 0, 1, 0, mk(3'd1, S_FETCH_OK, 2'b00), "j_fetch");
    cyc(3'd3, 0, 1, 0, mk(3'd2, S_PCW | S_J, 2'b00), "j_decode");
    cyc(3'd0, 0, 1, 0, mk(3'd1, S_FETCH_OK, 2'b00), "nop_fetch");
    cyc(3'd0, 0, 1, 0, mk(3'd2, S_NONE, 2'b00), "nop_decode");

    // ADDI
    cyc(3'd5, 0, 1, 0, mk(3'd1, S_FETCH_OK, 2'b00), "addi_fetch");
    cyc(3'd5, 0, 1, 0, mk(3'd2, S_NONE, 2'b00), "addi_decode");
    cyc(3'd5, 0, 1, 0, mk(3'd3, S_AS, 2'b10), "addi_exec");
    cyc(3'd5, 0, 1, 0, mk(3'd5, S_RW | S_AS, 2'b10), "addi_wb");

    // SUB
    cyc(3'd6, 0, 1, 0, mk(3'd1, S_FETCH_OK, 2'b00), "sub_fetch");
    cyc(3'd6, 0, 1, 0, mk(3'd2, S_NONE, 2'b00), "sub_decode");
    cyc(3'd6, 0, 1, 0, mk(3'd3, S_NONE, 2'b10), "sub_exec");
    cyc(3'd6, 0, 1, 0, mk(3'd5, S_RDST | S_RW, 2'b10), "sub_wb");

    // LW: mem_ready arrives exactly in the limit cycle and wins
    cyc(3'd1, 0, 1, 0, mk(3'd1, S_FETCH_OK, 2'b00), "lwto_fetch");
    cyc(3'd1, 0, 1, 0, mk(3'd2, S_NONE, 2'b00), "lwto_decode");
    cyc(3'd1, 0, 1, 0, mk(3'd3, S_AS, 2'b00), "lwto_exec");
    for (int i = 0; i < 15; i++)
      cyc(3'd1, 0, 0, 0, mk(3'd4, S_MR | S_AS, 2'b00), "lwto_mem_wait");
    cyc(3'd1, 0, 1, 0, mk(3'd4, S_MR | S_AS, 2'b00), "lwto_mem_limit_ready");
    cyc(3'd1, 0, 1, 0, mk(3'd5, S_RW | S_M2R, 2'b00), "lwto_wb_no_timeout");

    // FETCH starved: 16 waiting cycles, then ERROR with sticky flag
    for (int i = 0; i < 16; i++)
      cyc(3'd0, 0, 0, 0, mk(3'd1, S_MR, 2'b00), "fetch_wait");
    cyc(3'd0, 0, 1, 0, mk(3'd6, S_NONE, 2'b00, 1'b0, 1'b1), "fetch_timeout_err");
    cyc(3'd4, 0, 1, 0, mk(3'd6, S_NONE, 2'b00, 1'b0, 1'b1), "error_absorbing");
    cyc(3'd4, 0, 1, 1, mk(3'd6, S_NONE, 2'b00, 1'b0, 1'b1), "error_reset_cycle");
    cyc(3'd4, 0, 1, 0, mk(3'd0, S_NONE, 2'b00), "flags_cleared");

    // Opcode 7: branch when enabled, illegal otherwise
    cyc(3'd7, 0, 1, 0, mk(3'd1, S_FETCH_OK, 2'b00), "op7_fetch");
    cyc(3'd7, 0, 1, 0, mk(3'd2, S_NONE, 2'b00), "op7_decode");
`ifdef BEQ_EN
    cyc(3'd7, 1, 1, 0, mk(3'd3, S_NONE, 2'b01), "beq_exec");
    cyc(3'd7, 1, 1, 0, mk(3'd7, S_PCW | S_BT, 2'b01), "beq_taken");
    cyc(3'd7, 0, 1, 0, mk(3'd1, S_FETCH_OK, 2'b00), "beq2_fetch");
    cyc(3'd7, 0, 1, 0, mk(3'd2, S_NONE, 2'b00), "beq2_decode");
    cyc(3'd7, 0, 1, 0, mk(3'd3, S_NONE, 2'b01), "beq2_exec");
    cyc(3'd7, 0, 0, 0, mk(3'd7, S_NONE, 2'b01), "beq_not_taken");
    cyc(3'd7, 0, 0, 1, mk(3'd1, S_MR, 2'b00), "beq_reset_cycle");
`else
    cyc(3'd7, 0, 1, 0, mk(3'd6, S_NONE, 2'b00, 1'b1, 1'b0), "illegal_err");
    cyc(3'd0, 0, 1, 0, mk(3'd6, S_NONE, 2'b00, 1'b1, 1'b0), "illegal_sticky");
    cyc(3'd0, 0, 1, 1, mk(3'd6, S_NONE, 2'b00, 1'b1, 1'b0), "illegal_reset_cycle");
`endif
    cyc(3'd2, 0, 1, 0, mk(3'd0, S_NONE, 2'b00), "op7_after_reset");

    // Reset during SW MEM wait aborts the access
    cyc(3'd2, 0, 1, 0, mk(3'd1, S_FETCH_OK, 2'b00), "swr_fetch");
    cyc(3'd2, 0, 1, 0, mk(3'd2, S_NONE, 2'b00), "swr_decode");
    cyc(3'd2, 0, 0, 0, mk(3'd3, S_AS, 2'b00), "swr_exec");
    cyc(3'd2, 0, 0, 0, mk(3'd4, S_MW | S_AS, 2'b00), "swr_mem_wait");
    cyc(3'd2, 0, 0, 1, mk(3'd4, S_MW | S_AS, 2'b00), "swr_reset_cycle");
    cyc(3'd2, 0, 0, 0, mk(3'd0, S_NONE, 2'b00), "swr_idle");
    cyc(3'd2, 0, 0, 0, mk(3'd1, S_MR, 2'b00), "swr_refetch");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
